// File: rtl/ysyx_24110015_core_ctrl_pkg.sv
// Shared encodings for the NPC multi-cycle control FSM: states, PC source
// select, mcause codes and the bundled decoder flags.
package ysyx_24110015_core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_ID       = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam logic [1:0] PC_SEL_NPC   = 2'd0;
  localparam logic [1:0] PC_SEL_MTVEC = 2'd1;
  localparam logic [1:0] PC_SEL_MEPC  = 2'd2;

  localparam logic [3:0] CAUSE_IF_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic zicsr;
    logic ebreak;
    logic ecall;
    logic mret;
    logic illegal;
  } dec_t;

  // States that wait on an external handshake and are therefore timed.
  function automatic logic is_bus_state(input state_t s);
    return (s == S_IF_REQ) || (s == S_IF_WAIT) ||
           (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_24110015_timeout_cnt.sv
// Per-state bus watchdog: counts cycles spent waiting, flags expiry on the
// last allowed cycle. Cleared whenever the FSM leaves or is outside a bus state.
module ysyx_24110015_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  assign expired = inc && (cnt == LAST);

  // Holds at LAST so the count never wraps if the owner lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !expired) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/ysyx_24110015_core_ctrl.sv
// NPC multi-cycle control: sequences IF/ID/EX/MEM/WB, tracks a pending trap,
// emits one-cycle write enables and maintains mcycle/minstret.
module ysyx_24110015_core_ctrl
  import ysyx_24110015_core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_zicsr,
  input  logic             dec_ebreak,
  input  logic             dec_ecall,
  input  logic             dec_mret,
  input  logic             dec_illegal,
  output logic             inst_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             csr_we,
  output logic             trap_we,
  output logic [3:0]       trap_cause,
  output logic             halt,
  output logic             halt_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  dec_t       dec;
  logic       trap_pend;
  logic [3:0] cause_q;
  logic       halt_q;
  logic       halt_err_q;
  logic       bus_st;
  logic       hs;
  logic       tmo;

  assign dec = '{reg_write: dec_reg_write, mem_read: dec_mem_read,
                 mem_write: dec_mem_write, zicsr: dec_zicsr,
                 ebreak: dec_ebreak, ecall: dec_ecall,
                 mret: dec_mret, illegal: dec_illegal};

  // Handshake that completes the current bus state this cycle.
  always_comb begin
    bus_st = is_bus_state(state);
    hs     = 1'b0;
    case (state)
      S_IF_REQ:   hs = ifu_req_ready;
      S_IF_WAIT:  hs = ifu_rsp_valid;
      S_MEM_REQ:  hs = lsu_req_ready;
      S_MEM_WAIT: hs = lsu_rsp_valid;
      default:    hs = 1'b0;
    endcase
  end

  ysyx_24110015_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (!bus_st || hs),
    .inc     (bus_st),
    .expired (tmo)
  );

  // Handshake is always tested before the timeout so it wins a same-cycle tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IF_REQ;
      trap_pend  <= 1'b0;
      cause_q    <= '0;
      halt_q     <= 1'b0;
      halt_err_q <= 1'b0;
    end else begin
      case (state)
        S_IF_REQ: begin
          if (ifu_req_ready) state <= S_IF_WAIT;
          else if (tmo) begin
            state      <= S_HALT;
            halt_q     <= 1'b1;
            halt_err_q <= 1'b1;
          end
        end
        S_IF_WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              trap_pend <= 1'b1;
              cause_q   <= CAUSE_IF_FAULT;
              state     <= S_WB;
            end else begin
              state <= S_ID;
            end
          end else if (tmo) begin
            state      <= S_HALT;
            halt_q     <= 1'b1;
            halt_err_q <= 1'b1;
          end
        end
        S_ID: begin
          if (dec.illegal) begin
            trap_pend <= 1'b1;
            cause_q   <= CAUSE_ILLEGAL;
            state     <= S_EX;
          end else if (dec.ecall) begin
            trap_pend <= 1'b1;
            cause_q   <= CAUSE_ECALL_M;
            state     <= S_EX;
          end else if (dec.ebreak) begin
            state  <= S_HALT;
            halt_q <= 1'b1;
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          if ((dec.mem_read || dec.mem_write) && !trap_pend) state <= S_MEM_REQ;
          else state <= S_WB;
        end
        S_MEM_REQ: begin
          if (lsu_req_ready) state <= S_MEM_WAIT;
          else if (tmo) begin
            state      <= S_HALT;
            halt_q     <= 1'b1;
            halt_err_q <= 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            state <= S_WB;
            if (lsu_rsp_err) begin
              trap_pend <= 1'b1;
              cause_q   <= dec.mem_read ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            end
          end else if (tmo) begin
            state      <= S_HALT;
            halt_q     <= 1'b1;
            halt_err_q <= 1'b1;
          end
        end
        S_WB: begin
          state     <= S_IF_REQ;
          trap_pend <= 1'b0;
          cause_q   <= '0;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Fetch request is masked while reset is held so every output reads 0.
  always_comb begin
    ifu_req_valid = rst && (state == S_IF_REQ);
    lsu_req_valid = (state == S_MEM_REQ);
    inst_we       = (state == S_IF_WAIT) && ifu_rsp_valid && !ifu_rsp_err;
    pc_we         = 1'b0;
    pc_sel        = PC_SEL_NPC;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    trap_we       = 1'b0;
    if (state == S_WB) begin
      pc_we = 1'b1;
      if (trap_pend) begin
        trap_we = 1'b1;
        pc_sel  = PC_SEL_MTVEC;
      end else if (dec.mret) begin
        pc_sel = PC_SEL_MEPC;
      end else begin
        rf_we  = dec.reg_write;
        csr_we = dec.zicsr;
      end
    end
    trap_cause = trap_we ? cause_q : 4'd0;
    halt       = halt_q;
    halt_err   = halt_err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (state == S_WB && !trap_pend) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_core_ctrl.sv
// Directed bench for the NPC control FSM with hand-computed expectations.
module tb_ysyx_24110015_core_ctrl;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_zicsr;
  logic        dec_ebreak, dec_ecall, dec_mret, dec_illegal;
  logic        inst_we, pc_we, rf_we, csr_we, trap_we, halt, halt_err;
  logic [1:0]  pc_sel;
  logic [3:0]  trap_cause;
  logic [63:0] cycle_cnt, instret_cnt;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  int exp_ret = 0;

  ysyx_24110015_core_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_zicsr(dec_zicsr),
    .dec_ebreak(dec_ebreak), .dec_ecall(dec_ecall),
    .dec_mret(dec_mret), .dec_illegal(dec_illegal),
    .inst_we(inst_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .csr_we(csr_we), .trap_we(trap_we), .trap_cause(trap_cause),
    .halt(halt), .halt_err(halt_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic clr_dec();
    {dec_reg_write, dec_mem_read, dec_mem_write, dec_zicsr} = '0;
    {dec_ebreak, dec_ecall, dec_mret, dec_illegal} = '0;
  endtask

  task automatic clr_bus();
    {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err} = '0;
    {lsu_req_ready, lsu_rsp_valid, lsu_rsp_err} = '0;
  endtask

  // Hold reset across two edges, release just after an edge.
  task automatic do_reset();
    rst = 1'b0;
    clr_bus();
    clr_dec();
    step();
    step();
    rst = 1'b1;
    ncyc = 0;
    exp_ret = 0;
  endtask

  // Enters in IF_REQ; leaves in ID (ok) or WB (fault).
  task automatic fetch(input logic err);
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    #1 chk("if_req_valid", ifu_req_valid, 1);
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err   = err;
    #1 chk("inst_we", inst_we, !err);
    step();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
  endtask

  // From ID through a one-cycle memory access; leaves in WB.
  task automatic mem_op(input logic err);
    step();
    step();
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b1;
    lsu_rsp_err   = err;
    step();
    lsu_rsp_valid = 1'b0;
    lsu_rsp_err   = 1'b0;
  endtask

  task automatic wb_chk(input string t, input logic [1:0] sel, input logic rf,
                        input logic csr, input logic trap, input logic [3:0] cause);
    #1;
    chk({t, "_pc_we"}, pc_we, 1);
    chk({t, "_pc_sel"}, pc_sel, sel);
    chk({t, "_rf_we"}, rf_we, rf);
    chk({t, "_csr_we"}, csr_we, csr);
    chk({t, "_trap_we"}, trap_we, trap);
    chk({t, "_cause"}, trap_cause, cause);
    step();
    #1 chk({t, "_pc_we_pulse"}, pc_we, 0);
  endtask

  initial begin
    rst = 1'b0;
    clr_bus();
    clr_dec();
    #1;
    chk("rst_if_valid", ifu_req_valid, 0);
    chk("rst_lsu_valid", lsu_req_valid, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_halt", halt, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    do_reset();

    // ADDI: fetch at cycles 1-2, WB at cycle 5
    dec_reg_write = 1'b1;
    fetch(1'b0);
    step();
    step();
    #1 chk("addi_wb_cycle", cycle_cnt, 4);
    wb_chk("addi", 2'd0, 1, 0, 0, 4'd0);
    exp_ret++;
    chk("addi_instret", instret_cnt, exp_ret);

    // LW with delayed request ready and response
    clr_dec();
    dec_reg_write = 1'b1;
    dec_mem_read  = 1'b1;
    fetch(1'b0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      lsu_req_ready = (i == 3);
      #1 chk("lw_req_valid_hold", lsu_req_valid, 1);
      step();
    end
    lsu_req_ready = 1'b0;
    #1 chk("lw_req_valid_drop", lsu_req_valid, 0);
    step();
    lsu_rsp_valid = 1'b1;
    step();
    lsu_rsp_valid = 1'b0;
    wb_chk("lw", 2'd0, 1, 0, 0, 4'd0);
    exp_ret++;

    // Fetch access fault
    clr_dec();
    dec_reg_write = 1'b1;
    fetch(1'b1);
    wb_chk("iferr", 2'd1, 0, 0, 1, 4'd1);
    chk("iferr_instret", instret_cnt, exp_ret);

    // ecall, then illegal outranking ecall
    clr_dec();
    dec_ecall = 1'b1;
    fetch(1'b0);
    step();
    step();
    wb_chk("ecall", 2'd1, 0, 0, 1, 4'd11);
    dec_illegal = 1'b1;
    fetch(1'b0);
    step();
    step();
    wb_chk("illegal", 2'd1, 0, 0, 1, 4'd2);

    // mret retires without a register write
    clr_dec();
    dec_mret      = 1'b1;
    dec_reg_write = 1'b1;
    fetch(1'b0);
    step();
    step();
    wb_chk("mret", 2'd2, 0, 0, 0, 4'd0);
    exp_ret++;

    // CSR write
    clr_dec();
    dec_zicsr     = 1'b1;
    dec_reg_write = 1'b1;
    fetch(1'b0);
    step();
    step();
    wb_chk("csr", 2'd0, 1, 1, 0, 4'd0);
    exp_ret++;

    // Store and load access faults
    clr_dec();
    dec_mem_write = 1'b1;
    fetch(1'b0);
    mem_op(1'b1);
    wb_chk("sw_err", 2'd1, 0, 0, 1, 4'd7);
    clr_dec();
    dec_mem_read  = 1'b1;
    dec_reg_write = 1'b1;
    fetch(1'b0);
    mem_op(1'b1);
    wb_chk("lw_err", 2'd1, 0, 0, 1, 4'd5);
    chk("faults_instret", instret_cnt, exp_ret);
    chk("run_cycle", cycle_cnt, ncyc);

    // ebreak halts without error, counters freeze
    clr_dec();
    dec_ebreak = 1'b1;
    fetch(1'b0);
    step();
    chk("ebreak_halt", halt, 1);
    chk("ebreak_halt_err", halt_err, 0);
    begin
      int frozen;
      frozen = ncyc;
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      repeat (3) step();
      #1;
      chk("halt_if_valid", ifu_req_valid, 0);
      chk("halt_inst_we", inst_we, 0);
      chk("halt_cycle_frozen", cycle_cnt, frozen);
      clr_bus();
    end

    // Reset asserted mid-MEM_WAIT with a response arriving
    do_reset();
    dec_mem_read  = 1'b1;
    dec_reg_write = 1'b1;
    fetch(1'b0);
    step();
    step();
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_if_valid", ifu_req_valid, 0);
    chk("mid_rst_lsu_valid", lsu_req_valid, 0);
    chk("mid_rst_pc_we", pc_we, 0);
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_cycle", cycle_cnt, 0);
    chk("mid_rst_instret", instret_cnt, 0);
    step();
    rst = 1'b1;
    ncyc = 0;
    clr_dec();
    #1 chk("rel_if_valid", ifu_req_valid, 1);

    // Stale LSU response ignored; handshake wins on the expiry cycle
    repeat (7) step();
    chk("tie_no_halt_pre", halt, 0);
    chk("tie_stale_lsu", lsu_req_valid, 0);
    lsu_rsp_valid = 1'b0;
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("tie_no_halt", halt, 0);
    ifu_rsp_valid = 1'b1;
    #1 chk("tie_inst_we", inst_we, 1);
    step();
    ifu_rsp_valid = 1'b0;
    step();
    step();
    wb_chk("tie_nop", 2'd0, 0, 0, 0, 4'd0);
    chk("tie_instret", instret_cnt, 1);

    // Fetch timeout
    do_reset();
    repeat (7) step();
    chk("tmo_before", halt, 0);
    step();
    chk("tmo_halt", halt, 1);
    chk("tmo_halt_err", halt_err, 1);
    chk("tmo_cycle", cycle_cnt, 8);
    repeat (3) step();
    chk("tmo_cycle_frozen", cycle_cnt, 8);
    chk("tmo_if_valid", ifu_req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_core_ctrl.md
# ysyx_24110015_core_ctrl

Multi-cycle control FSM for the NPC core. It drives the fetch and load/store handshakes and steps each instruction through fetch, decode, execute, memory and writeback. It consumes the decoder's per-instruction control flags and produces the one-cycle write enables for the instruction register, PC, register file, CSRs and trap state. It also supplies the mcycle/minstret counters and detects bus timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in any single bus state before a fatal halt. Must be ≥2.
- CNT_W, 64: width of the cycle and instret counters.

Ports:
- clk  in  1  single core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_err  in  1  fetch access fault, qualified by ifu_rsp_valid.
- lsu_req_valid  out  1  load/store request.
- lsu_req_ready  in  1  load/store request accepted.
- lsu_rsp_valid  in  1  load/store completion.
- lsu_rsp_err  in  1  load/store access fault, qualified by lsu_rsp_valid.
- dec_reg_write, dec_mem_read, dec_mem_write, dec_zicsr, dec_ebreak, dec_ecall, dec_mret, dec_illegal  in  1 each  decoder flags. Stable from ID through WB.
- inst_we  out  1  latch the fetched instruction.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = datapath next-PC, 1 = mtvec, 2 = mepc.
- rf_we  out  1  register-file write.
- csr_we  out  1  CSR instruction write.
- trap_we  out  1  write mepc/mcause.
- trap_cause  out  4  mcause code, valid while trap_we is high.
- halt  out  1  core stopped (sticky).
- halt_err  out  1  the halt was caused by a timeout.
- cycle_cnt  out  CNT_W  mcycle.
- instret_cnt  out  CNT_W  minstret.

## Operation
- States: IF_REQ, IF_WAIT, ID, EX, MEM_REQ, MEM_WAIT, WB, HALT.
- IF_REQ:
  - ifu_req_valid=1.
  - On ifu_req_ready, go to IF_WAIT.
- IF_WAIT:
  - On ifu_rsp_valid with no error: inst_we=1 for this cycle, go to ID.
  - On ifu_rsp_valid with ifu_rsp_err: inst_we=0, record cause 1, go to WB with the trap pending.
- ID: one cycle, then EX. Trap causes are resolved here, in priority order:
  - dec_illegal gives cause 2.
  - dec_ecall gives cause 11.
  - dec_ebreak goes directly to HALT with halt=1 and halt_err=0.
- EX:
  - If dec_mem_read or dec_mem_write and no trap is pending, go to MEM_REQ.
  - Otherwise go to WB.
- MEM_REQ:
  - lsu_req_valid=1.
  - On lsu_req_ready, go to MEM_WAIT.
- MEM_WAIT:
  - On lsu_rsp_valid, go to WB.
  - If lsu_rsp_err is set, record cause 5 for a load or 7 for a store.
- WB: held for exactly one cycle, then IF_REQ. Outputs in WB:
  - pc_we=1 always.
  - Trap pending: trap_we=1, pc_sel=1, rf_we=0, csr_we=0.
  - Else dec_mret: pc_sel=2, rf_we=0.
  - Else: pc_sel=0, rf_we=dec_reg_write, csr_we=dec_zicsr.
  - A load access fault suppresses rf_we.
- HALT:
  - Terminal; all request and enable outputs are 0.
  - Exits only through reset.
- Timeout:
  - A counter clears on every state change and increments in IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without a handshake completing, go to HALT with halt=1 and halt_err=1.
  - If a handshake completes in the same cycle as the timeout, the handshake wins.
- cycle_cnt increments every cycle while not in HALT.
- instret_cnt increments in WB only when no trap is pending. mret counts as retired.
- Both counters wrap modulo 2^CNT_W with no flag.

## Timing
- Reset (rst=0): state=IF_REQ, every output 0, counters 0, pending trap cleared.
- Reset is asynchronous and may arrive in any state. Any handshake response arriving after reset deasserts is ignored until the corresponding request has been reissued.
- ifu_req_valid is 1 in the first cycle after rst deasserts.
- Request valid signals stay high until their ready is seen. They are Moore outputs decoded from the state register.
- A response is accepted no earlier than the cycle after its request is accepted.
- Minimum latency for a non-memory instruction is 5 cycles (IF_REQ, IF_WAIT, ID, EX, WB).
- Minimum latency for a load or store is 7 cycles.
- inst_we, pc_we, rf_we, csr_we and trap_we are each at most one-cycle pulses.

## Structure
- Shared constants go in the common macros header:
  - state encodings, 3 bits;
  - pc_sel encodings;
  - cause codes 1, 2, 5, 7 and 11.
- One sub-module, ysyx_24110015_timeout_cnt, holds the clear/increment/expire counter, parameterised by TIMEOUT_CYCLES.
- The FSM, the pending-trap register and the performance counters live in the top module.

## Test plan
- ADDI with ready/valid both high → inst_we at cycle 2, WB at cycle 5 with pc_we=1, rf_we=1, pc_sel=0; instret_cnt=1.
- LW with lsu_req_ready delayed 3 cycles and lsu_rsp_valid 2 cycles later → lsu_req_valid held high for 4 cycles; rf_we=1 in WB.
- Fetch with ifu_rsp_err=1 → no inst_we; WB has trap_we=1, trap_cause=1, pc_sel=1; instret_cnt is unchanged.
- ecall → trap_cause=11. mret → pc_sel=2 with rf_we=0. SW with lsu_rsp_err=1 → trap_cause=7.
- With TIMEOUT_CYCLES=8 and ifu_req_ready tied to 0 → HALT entered at cycle 8, halt=1, halt_err=1, cycle_cnt frozen at 8.
- ebreak → halt=1 with halt_err=0. Then rst asserted mid-MEM_WAIT → all outputs 0 immediately, and ifu_req_valid=1 the cycle after release.
